// File: rtl/dataflow_pkg.sv
// Shared helpers for the dataflow arith library: antitoken counter sizing
// and flat-bus slicing.
package dataflow_pkg;

    // Bits needed to hold a count in 0..kill_depth.
    function automatic int cnt_width(input int kill_depth);
        return $clog2(kill_depth + 1);
    endfunction

    // Low bit of channel idx in a flat bus of w-bit channels.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/antitoken_counter.sv
// Pending-antitoken counter for one input channel: counts tokens that must be
// discarded, and kills them as they arrive.
module antitoken_counter
    import dataflow_pkg::*;
#(
    parameter int KILL_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pvalid,
    input  logic add,
    output logic kill_out,
    output logic full,
    output logic pending
);
    localparam int CW = cnt_width(KILL_DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;

    assign pending  = (cnt_q != '0);
    assign kill_out = pvalid & pending;
    assign full     = (cnt_q == CW'(KILL_DEPTH));

    // Simultaneous add and kill cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (add & !kill_out)
            cnt_d = cnt_q + CW'(1);
        else if (!add & kill_out)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/select_n_antitoken.sv
// N-way elastic select with per-channel antitoken counters.
// Optional one-slot output register enabled by defining SELECT_N_OUT_REG_EN.
module select_n_antitoken
    import dataflow_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_TYPE  = 32,
    parameter int SEL_TYPE   = $clog2(NUM_INPUTS),
    parameter int KILL_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SEL_TYPE-1:0]             condition,
    input  logic                            condition_valid,
    output logic                            condition_ready,
    input  logic [NUM_INPUTS*DATA_TYPE-1:0] ins,
    input  logic [NUM_INPUTS-1:0]           ins_valid,
    output logic [NUM_INPUTS-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]            result,
    output logic                            result_valid,
    input  logic                            result_ready
);
    logic [NUM_INPUTS-1:0] is_sel, pending, full_cnt, kill, add;
    logic                  in_range, sel_valid, sel_pending, ovf_block;
    logic                  out_valid, out_ready, fire;
    logic [DATA_TYPE-1:0]  sel_data;

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt
        antitoken_counter #(.KILL_DEPTH(KILL_DEPTH)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .pvalid   (ins_valid[g]),
            .add      (add[g]),
            .kill_out (kill[g]),
            .full     (full_cnt[g]),
            .pending  (pending[g])
        );
    end

    always_comb begin
        is_sel      = '0;
        in_range    = 1'b0;
        sel_valid   = 1'b0;
        sel_pending = 1'b0;
        ovf_block   = 1'b0;
        sel_data    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (condition == SEL_TYPE'(i)) begin
                is_sel[i]   = 1'b1;
                in_range    = 1'b1;
                sel_valid   = ins_valid[i];
                sel_pending = pending[i];
                sel_data    = ins[slice_lo(i, DATA_TYPE) +: DATA_TYPE];
            end else begin
                ovf_block = ovf_block | (full_cnt[i] & !ins_valid[i]);
            end
        end
        // Held low during reset so nothing is handshaken while counters clear.
        out_valid = !rst & condition_valid & in_range & sel_valid & !sel_pending & !ovf_block;
        fire      = out_valid & out_ready;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            // A pending count accepts the token being killed, including on sel.
            ins_ready[i] = pending[i] | fire;
            add[i]       = fire & !is_sel[i] & (kill[i] | !ins_valid[i]);
        end
        condition_ready = fire;
    end

`ifdef SELECT_N_OUT_REG_EN
    logic                 full_q, full_d;
    logic [DATA_TYPE-1:0] data_q, data_d;

    assign out_ready = !full_q | result_ready;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (fire) begin
            full_d = 1'b1;
            data_d = sel_data;
        end else if (result_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign result       = data_q;
    assign result_valid = full_q;
`else
    assign out_ready    = result_ready;
    assign result       = sel_data;
    assign result_valid = out_valid;
`endif

endmodule

// File: tb/tb_select_n_antitoken.sv
// Scoreboard bench for select_n_antitoken; follows SELECT_N_OUT_REG_EN if defined.
module tb_select_n_antitoken;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int KD = 2;
`ifdef SELECT_N_OUT_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   condition;
    logic            condition_valid, condition_ready;
    logic [N*DW-1:0] ins;
    logic [N-1:0]    ins_valid, ins_ready;
    logic [DW-1:0]   result;
    logic            result_valid, result_ready;

    always #5 clk = ~clk;

    select_n_antitoken #(
        .NUM_INPUTS(N), .DATA_TYPE(DW), .SEL_TYPE(SW), .KILL_DEPTH(KD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .condition       (condition),
        .condition_valid (condition_valid),
        .condition_ready (condition_ready),
        .ins             (ins),
        .ins_valid       (ins_valid),
        .ins_ready       (ins_ready),
        .result          (result),
        .result_valid    (result_valid),
        .result_ready    (result_ready)
    );

    int            n_chk = 0;
    int            n_err = 0;
    int            m_cnt [N];
    bit            m_full;
    logic [DW-1:0] sb [$];
    logic [N-1:0]  s_ready;
    logic          s_cr, s_rv;
    logic [DW-1:0] s_res, s_ch2;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ch(input int i);
        return ins[i*DW +: DW];
    endfunction

    task automatic drive(input bit cv, input int cond, input logic [N-1:0] iv, input bit rr);
        condition_valid = cv;
        condition       = SW'(cond);
        ins_valid       = iv;
        result_ready    = rr;
        for (int i = 0; i < N; i++) ins[i*DW +: DW] = $urandom;
    endtask

    // One clock: model and compare at negedge, advance model at posedge.
    task automatic cyc();
        bit            inr, ovf, ov, ordy, fire;
        int            sel;
        logic [N-1:0]  er;
        @(negedge clk);
        if (rst) begin
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
            m_full = 1'b0;
            sb.delete();
        end
        sel = int'(condition);
        inr = (sel < N);
        ovf = 1'b0;
        for (int j = 0; j < N; j++)
            if (inr && j != sel && m_cnt[j] == KD && !ins_valid[j]) ovf = 1'b1;
        ov   = !rst && condition_valid && inr && ins_valid[sel] && m_cnt[sel] == 0 && !ovf;
        ordy = REG ? (!m_full || result_ready) : result_ready;
        fire = ov && ordy;
        for (int j = 0; j < N; j++) er[j] = (m_cnt[j] > 0) || fire;
        chk("ins_ready", 32'(ins_ready), 32'(er));
        chk("cond_ready", 32'(condition_ready), 32'(fire));
        chk("res_valid", 32'(result_valid), 32'(REG ? m_full : ov));
        if (fire) sb.push_back(ch(sel));
        if (result_valid && result_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("result", result, sb.pop_front());
        end
        s_ready = ins_ready; s_cr = condition_ready; s_rv = result_valid;
        s_res = result; s_ch2 = ch(2);
        @(posedge clk);
        for (int j = 0; j < N; j++) begin
            bit kill, add;
            kill = ins_valid[j] && m_cnt[j] > 0;
            add  = fire && j != sel && !(ins_valid[j] && m_cnt[j] == 0);
            m_cnt[j] = rst ? 0 : m_cnt[j] + int'(add) - int'(kill);
        end
        if (rst)            m_full = 1'b0;
        else if (fire)      m_full = 1'b1;
        else if (result_ready) m_full = 1'b0;
        #1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) m_cnt[j] = 0;
        m_full = 1'b0;
        rst = 1'b1;
        drive(1'b0, 0, 4'b0000, 1'b1);
        cyc();
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_rv", 32'(s_rv), 32'd0);
        cyc();
        rst = 1'b0;

        // All valid, select 2
        drive(1'b1, 2, 4'b1111, 1'b1); cyc();
        chk("t1_ready", 32'(s_ready), 32'hf);
`ifndef SELECT_N_OUT_REG_EN
        chk("t1_result", s_res, s_ch2);
`endif
        // Only selected valid: other channels owe antitokens
        drive(1'b1, 2, 4'b0100, 1'b1); cyc();
        chk("t2_ready_fire", 32'(s_ready), 32'hf);
        drive(1'b0, 0, 4'b1011, 1'b1); cyc();
        chk("t2_kill_ready", 32'(s_ready), 32'hb);
        drive(1'b0, 0, 4'b0000, 1'b1); cyc();
        chk("t2_drained", 32'(s_ready), 32'h0);

        // Overflow block at KILL_DEPTH
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        chk("t3_blocked", 32'(s_cr), 32'd0);
        drive(1'b0, 0, 4'b1110, 1'b1); cyc();
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        chk("t3_unblocked", 32'(s_cr), 32'd1);
        drive(1'b0, 0, 4'b1110, 1'b1); cyc();
        drive(1'b0, 0, 4'b1110, 1'b1); cyc();

        // Stale token on selected channel is killed first
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        drive(1'b1, 1, 4'b1110, 1'b1); cyc();
        chk("t4_kill_sel", 32'(s_cr), 32'd0);
        chk("t4_kill_ready", 32'(s_ready), 32'he);
        drive(1'b1, 1, 4'b0010, 1'b1); cyc();
        chk("t4_forward", 32'(s_cr), 32'd1);
        drive(1'b0, 0, 4'b1101, 1'b1); cyc();

        // Out-of-range condition
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5, 4'b1111, 1'b1); cyc();
            chk("t5_oor_cr", 32'(s_cr), 32'd0);
            chk("t5_oor_ready", 32'(s_ready), 32'h0);
        end

        // Async reset with pending counters
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        rst = 1'b1;
        drive(1'b1, 0, 4'b0001, 1'b1); cyc();
        chk("t5_rst_ready", 32'(s_ready), 32'h0);
        chk("t5_rst_rv", 32'(s_rv), 32'd0);
        rst = 1'b0;
        drive(1'b0, 0, 4'b1110, 1'b1); cyc();
        chk("t5_cleared", 32'(s_ready), 32'h0);

        // Backpressure toggle then random traffic
        drive(1'b1, 3, 4'b1111, 1'b1); cyc();
        drive(1'b1, 1, 4'b1111, 1'b0); cyc();
        drive(1'b1, 2, 4'b1111, 1'b1); cyc();
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 4),
                  N'($urandom), ($urandom_range(0, 3) != 0));
            cyc();
        end
        drive(1'b0, 0, 4'b1111, 1'b1); cyc();
        drive(1'b0, 0, 4'b1111, 1'b1); cyc();
        drive(1'b0, 0, 4'b0000, 1'b1); cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
